// File: rtl/id_scoreboard_if.sv
// ID-stage scoreboard bus: decoded instruction, bypass/completion inputs and
// resolved operand / hazard outputs. clk and rst stay outside the bundle.
interface id_scoreboard_if #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int NFWD   = 2,
    parameter int MAXOUT = 4
);
    localparam int CW = $clog2(MAXOUT + 1);

    logic                 id_valid;
    logic                 flush;
    logic                 ex_ready;
    logic                 rs1_re;
    logic                 rs2_re;
    logic [AW-1:0]        rs1_addr;
    logic [AW-1:0]        rs2_addr;
    logic                 rd_we;
    logic [AW-1:0]        rd_addr;
    logic                 rd_long;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      rf_rdata1;
    logic [XLEN-1:0]      rf_rdata2;
    logic [NFWD-1:0]      fwd_we;
    logic [NFWD*AW-1:0]   fwd_addr;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 wb_long_valid;
    logic [AW-1:0]        wb_long_addr;
    logic [XLEN-1:0]      wb_long_data;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic                 issue;
    logic                 stallreq;
    logic [NREG-1:0]      busy_vec;
    logic [CW-1:0]        pend_cnt;
    logic                 sb_err;

    modport master (
        output id_valid, flush, ex_ready, rs1_re, rs2_re, rs1_addr, rs2_addr,
               rd_we, rd_addr, rd_long, imm, rf_rdata1, rf_rdata2,
               fwd_we, fwd_addr, fwd_data, wb_long_valid, wb_long_addr, wb_long_data,
        input  op1, op2, issue, stallreq, busy_vec, pend_cnt, sb_err
    );

    modport slave (
        input  id_valid, flush, ex_ready, rs1_re, rs2_re, rs1_addr, rs2_addr,
               rd_we, rd_addr, rd_long, imm, rf_rdata1, rf_rdata2,
               fwd_we, fwd_addr, fwd_data, wb_long_valid, wb_long_addr, wb_long_data,
        output op1, op2, issue, stallreq, busy_vec, pend_cnt, sb_err
    );
endinterface

// File: rtl/id_scoreboard.sv
// ID-stage operand resolution and long-latency write scoreboard: tracks
// outstanding load/div destinations, raises RAW/WAW/capacity stalls.
module id_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int NFWD   = 2,
    parameter int MAXOUT = 4
) (
    input logic           clk,
    input logic           rst,
    id_scoreboard_if.slave sb
);
    localparam int CW = $clog2(MAXOUT + 1);

    logic [NREG-1:0] busy;
    logic [CW-1:0]   cnt;
    logic            err;

    logic            wbhit1, wbhit2;
    logic            raw, waw, full, stall, iss;
    logic            set_en, clr_en, err_en;
    logic [XLEN-1:0] res1, res2;

    // Youngest bypass wins, so walk from oldest to youngest and let later hits overwrite.
    function automatic logic [XLEN-1:0] resolve(
        input logic                 re,
        input logic [AW-1:0]        addr,
        input logic [XLEN-1:0]      rf,
        input logic [XLEN-1:0]      immv,
        input logic [NFWD-1:0]      fwe,
        input logic [NFWD*AW-1:0]   faddr,
        input logic [NFWD*XLEN-1:0] fdata,
        input logic                 wbv,
        input logic [AW-1:0]        wba,
        input logic [XLEN-1:0]      wbd
    );
        logic [XLEN-1:0] v;
        int unsigned     i;
        v = rf;
        if (wbv && wba == addr) v = wbd;
        for (int unsigned k = 0; k < NFWD; k++) begin
            i = NFWD - 1 - k;
            if (fwe[i] && faddr[i*AW +: AW] == addr) v = fdata[i*XLEN +: XLEN];
        end
        if (addr == '0) v = '0;
        if (!re) v = immv;
        return v;
    endfunction

    always_comb begin
        res1 = resolve(sb.rs1_re, sb.rs1_addr, sb.rf_rdata1, sb.imm, sb.fwd_we, sb.fwd_addr,
                       sb.fwd_data, sb.wb_long_valid, sb.wb_long_addr, sb.wb_long_data);
        res2 = resolve(sb.rs2_re, sb.rs2_addr, sb.rf_rdata2, sb.imm, sb.fwd_we, sb.fwd_addr,
                       sb.fwd_data, sb.wb_long_valid, sb.wb_long_addr, sb.wb_long_data);
    end

    always_comb begin
        wbhit1 = sb.wb_long_valid && (sb.wb_long_addr == sb.rs1_addr);
        wbhit2 = sb.wb_long_valid && (sb.wb_long_addr == sb.rs2_addr);
        raw    = (sb.rs1_re && busy[sb.rs1_addr] && !wbhit1)
              || (sb.rs2_re && busy[sb.rs2_addr] && !wbhit2);
        waw    = sb.rd_we && (sb.rd_addr != '0) && busy[sb.rd_addr];
        full   = sb.rd_we && sb.rd_long && (cnt == CW'(MAXOUT));
        stall  = !rst && sb.id_valid && !sb.flush && (raw || waw || full);
        iss    = !rst && sb.id_valid && !sb.flush && !stall && sb.ex_ready;
        set_en = iss && sb.rd_we && sb.rd_long && (sb.rd_addr != '0);
        clr_en = sb.wb_long_valid && (sb.wb_long_addr != '0) && busy[sb.wb_long_addr];
        err_en = sb.wb_long_valid && (sb.wb_long_addr != '0) && !busy[sb.wb_long_addr];
    end

    // WAW stall guarantees set and clear never target the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            if (set_en) busy[sb.rd_addr] <= 1'b1;
            if (clr_en) busy[sb.wb_long_addr] <= 1'b0;
            if (set_en && !clr_en)      cnt <= cnt + CW'(1);
            else if (!set_en && clr_en) cnt <= cnt - CW'(1);
            if (err_en) err <= 1'b1;
        end
    end

    always_comb begin
        sb.op1      = rst ? '0 : res1;
        sb.op2      = rst ? '0 : res2;
        sb.stallreq = stall;
        sb.issue    = iss;
        sb.busy_vec = busy;
        sb.pend_cnt = cnt;
        sb.sb_err   = err;
    end
endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed scenarios plus randomized traffic, all
// checked against a set/array reference model of the scoreboard rules.
module tb_id_scoreboard;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int NFWD   = 2;
    localparam int MAXOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    id_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NFWD(NFWD), .MAXOUT(MAXOUT)) bus ();

    id_scoreboard #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NFWD(NFWD), .MAXOUT(MAXOUT)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit m_busy [NREG];
    int m_cnt;
    bit m_err;

    logic [XLEN-1:0] e_op1, e_op2;
    bit e_stall, e_issue, do_set, do_clr, do_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NREG-1:0] m_vec();
        logic [NREG-1:0] v;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic [XLEN-1:0] m_operand(input bit re, input int addr,
                                                  input logic [XLEN-1:0] rf);
        if (!re) return bus.imm;
        if (addr == 0) return '0;
        for (int i = 0; i < NFWD; i++)
            if (bus.fwd_we[i] && int'(bus.fwd_addr[i*AW +: AW]) == addr)
                return bus.fwd_data[i*XLEN +: XLEN];
        if (bus.wb_long_valid && int'(bus.wb_long_addr) == addr) return bus.wb_long_data;
        return rf;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic eval_model();
        bit h1, h2, raw, waw, full;
        int r1, r2, rd, wa;
        r1 = int'(bus.rs1_addr); r2 = int'(bus.rs2_addr);
        rd = int'(bus.rd_addr);  wa = int'(bus.wb_long_addr);
        e_op1 = m_operand(bus.rs1_re, r1, bus.rf_rdata1);
        e_op2 = m_operand(bus.rs2_re, r2, bus.rf_rdata2);
        h1   = bus.wb_long_valid && wa == r1;
        h2   = bus.wb_long_valid && wa == r2;
        raw  = (bus.rs1_re && m_busy[r1] && !h1) || (bus.rs2_re && m_busy[r2] && !h2);
        waw  = bus.rd_we && rd != 0 && m_busy[rd];
        full = bus.rd_we && bus.rd_long && m_cnt == MAXOUT;
        e_stall = bus.id_valid && !bus.flush && (raw || waw || full);
        e_issue = bus.id_valid && !bus.flush && !e_stall && bus.ex_ready;
        do_set  = e_issue && bus.rd_we && bus.rd_long && rd != 0;
        do_clr  = bus.wb_long_valid && wa != 0 && m_busy[wa];
        do_err  = bus.wb_long_valid && wa != 0 && !m_busy[wa];
    endtask

    // Inputs are set after a negedge; check before the posedge, then advance the model.
    task automatic cycle();
        #1;
        eval_model();
        check("op1", bus.op1, e_op1);
        check("op2", bus.op2, e_op2);
        check("stallreq", bus.stallreq, e_stall);
        check("issue", bus.issue, e_issue);
        check("busy_vec", bus.busy_vec, m_vec());
        check("pend_cnt", bus.pend_cnt, m_cnt);
        check("sb_err", bus.sb_err, m_err);
        @(posedge clk);
        if (do_clr) begin m_busy[bus.wb_long_addr] = 1'b0; m_cnt--; end
        if (do_set) begin m_busy[bus.rd_addr] = 1'b1; m_cnt++; end
        if (do_err) m_err = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.flush = 0; bus.ex_ready = 1;
        bus.rs1_re = 0; bus.rs2_re = 0; bus.rs1_addr = '0; bus.rs2_addr = '0;
        bus.rd_we = 0; bus.rd_addr = '0; bus.rd_long = 0; bus.imm = '0;
        bus.rf_rdata1 = '0; bus.rf_rdata2 = '0;
        bus.fwd_we = '0; bus.fwd_addr = '0; bus.fwd_data = '0;
        bus.wb_long_valid = 0; bus.wb_long_addr = '0; bus.wb_long_data = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst_busy", bus.busy_vec, 0);
        check("rst_pend", bus.pend_cnt, 0);
        check("rst_err", bus.sb_err, 0);
        check("rst_op1", bus.op1, 0);
        check("rst_stall", bus.stallreq, 0);
        check("rst_issue", bus.issue, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic long_issue(input int rd);
        idle();
        bus.id_valid = 1; bus.rd_we = 1; bus.rd_long = 1; bus.rd_addr = AW'(rd);
        cycle();
    endtask

    initial begin
        int q[$];
        idle();
        m_reset();
        @(negedge clk);
        apply_reset();

        // forwarding priority
        idle();
        bus.rs1_re = 1; bus.rs1_addr = 5'd5; bus.rf_rdata1 = 32'h22222222;
        bus.fwd_we = 2'b11; bus.fwd_addr = {5'd5, 5'd5}; bus.fwd_data = {32'h11111111, 32'hAAAA0000};
        #1 check("fwd0_prio", bus.op1, 32'hAAAA0000);
        cycle();
        bus.fwd_we = 2'b10;
        #1 check("fwd1_prio", bus.op1, 32'h11111111);
        cycle();
        bus.fwd_we = 2'b00;
        #1 check("rf_fallback", bus.op1, 32'h22222222);
        cycle();

        // load-use
        long_issue(7);
        idle();
        bus.id_valid = 1; bus.rs2_re = 1; bus.rs2_addr = 5'd7; bus.rf_rdata2 = 32'hDEAD;
        #1 check("lu_stall", bus.stallreq, 1);
        check("lu_noissue", bus.issue, 0);
        cycle();
        cycle();
        bus.wb_long_valid = 1; bus.wb_long_addr = 5'd7; bus.wb_long_data = 32'h1234;
        #1 check("lu_release", bus.stallreq, 0);
        check("lu_op2", bus.op2, 32'h1234);
        cycle();
        idle();
        #1 check("lu_cleared", bus.busy_vec[7], 0);
        cycle();

        // capacity limit
        apply_reset();
        for (int r = 1; r <= 4; r++) long_issue(r);
        #1 check("full_cnt", bus.pend_cnt, 4);
        idle();
        bus.id_valid = 1; bus.rd_we = 1; bus.rd_long = 1; bus.rd_addr = 5'd5;
        bus.wb_long_valid = 1; bus.wb_long_addr = 5'd2;
        #1 check("full_stall", bus.stallreq, 1);
        cycle();
        #1 check("full_drain", bus.pend_cnt, 3);
        bus.wb_long_addr = 5'd3;
        #1 check("setclr_issue", bus.issue, 1);
        cycle();
        idle();
        #1 check("setclr_cnt", bus.pend_cnt, 3);
        cycle();

        // WAW and x0
        apply_reset();
        long_issue(9);
        idle();
        bus.id_valid = 1; bus.rd_we = 1; bus.rd_addr = 5'd9;
        #1 check("waw_stall", bus.stallreq, 1);
        cycle();
        long_issue(0);
        idle();
        #1 check("x0_cnt", bus.pend_cnt, 1);
        check("x0_busy", bus.busy_vec[0], 0);
        bus.rs1_re = 1; bus.rs1_addr = '0; bus.rf_rdata1 = 32'hFFFFFFFF;
        bus.fwd_we = 2'b01; bus.fwd_data = {32'h0, 32'h5555AAAA};
        #1 check("x0_read", bus.op1, 0);
        cycle();

        // error flag and async reset
        apply_reset();
        long_issue(1); long_issue(2); long_issue(4);
        idle();
        bus.wb_long_valid = 1; bus.wb_long_addr = 5'd3;
        cycle();
        idle();
        #1 check("err_set", bus.sb_err, 1);
        check("err_cnt", bus.pend_cnt, 3);
        bus.id_valid = 1; bus.rs1_re = 1; bus.rs1_addr = 5'd6; bus.rf_rdata1 = 32'h77;
        #1 rst = 1'b1;
        #1 check("arst_busy", bus.busy_vec, 0);
        check("arst_cnt", bus.pend_cnt, 0);
        check("arst_err", bus.sb_err, 0);
        check("arst_op1", bus.op1, 0);
        check("arst_issue", bus.issue, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                idle();
                apply_reset();
            end
            bus.id_valid  = $urandom_range(0, 9) < 8;
            bus.flush     = $urandom_range(0, 9) == 0;
            bus.ex_ready  = $urandom_range(0, 9) < 8;
            bus.rs1_re    = $urandom_range(0, 1);
            bus.rs2_re    = $urandom_range(0, 1);
            bus.rs1_addr  = AW'($urandom_range(0, 7));
            bus.rs2_addr  = AW'($urandom_range(0, 7));
            bus.rd_we     = $urandom_range(0, 1);
            bus.rd_long   = $urandom_range(0, 1);
            bus.rd_addr   = AW'($urandom_range(0, 7));
            bus.imm       = $urandom;
            bus.rf_rdata1 = $urandom;
            bus.rf_rdata2 = $urandom;
            bus.fwd_we    = NFWD'($urandom);
            for (int i = 0; i < NFWD; i++) begin
                bus.fwd_addr[i*AW +: AW]   = AW'($urandom_range(0, 7));
                bus.fwd_data[i*XLEN +: XLEN] = $urandom;
            end
            q.delete();
            for (int i = 1; i < NREG; i++) if (m_busy[i]) q.push_back(i);
            bus.wb_long_valid = $urandom_range(0, 9) < 4;
            if (q.size() > 0 && $urandom_range(0, 99) < 85)
                bus.wb_long_addr = AW'(q[$urandom_range(0, q.size() - 1)]);
            else
                bus.wb_long_addr = AW'($urandom_range(0, 7));
            bus.wb_long_data = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
